// File: rtl/sd_stream_reader.sv
// sd_stream_reader
//   Streams a run of 512-byte blocks from an sd_controller into a show-ahead
//   output FIFO. Each block is requested with a one-cycle sd_rd pulse, its
//   bytes are packed little-endian into DATA_W-bit words, and a new block is
//   only requested once the FIFO can absorb a whole block.
//
// Parameters
//   DATA_W      output word width (8, 16 or 32)
//   FIFO_WORDS  output FIFO depth in words (power of 2, >= 4096/DATA_W)
//   ADDR_MODE   0 = byte addressing (+512 per block), 1 = block addressing (+1)
//
// Ports
//   clk_25mhz, rst           clock, synchronous active-high reset
//   start, start_addr,       run request (accepted only when idle) with first
//   num_blocks               block address and block count
//   abort                    stop at the next block boundary
//   sd_ready, sd_byte_available, sd_dout   sd_controller status and byte stream
//   sd_rd, sd_address        block read request and address to sd_controller
//   m_data, m_valid, m_ready FIFO head word, not-empty flag, consumer pop
//   busy, done, blocks_done  run status, completion pulse, completed blocks
//   overflow                 sticky: a word was dropped on a full FIFO
module sd_stream_reader #(
  parameter int DATA_W     = 8,
  parameter int FIFO_WORDS = 512,
  parameter int ADDR_MODE  = 0
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       start_addr,
  input  logic [15:0]       num_blocks,
  input  logic              abort,
  input  logic              sd_ready,
  input  logic              sd_byte_available,
  input  logic [7:0]        sd_dout,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       blocks_done,
  output logic              overflow
);

  localparam int LANES       = DATA_W / 8;
  localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW          = $clog2(FIFO_WORDS);
  localparam int BLOCK_WORDS = 4096 / DATA_W;

  localparam logic [31:0]       ADDR_STEP = (ADDR_MODE == 0) ? 32'd512 : 32'd1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [AW:0]       DEPTH     = (AW + 1)'(FIFO_WORDS);
  localparam logic [AW:0]       NEED      = (AW + 1)'(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    ISSUE,
    RECV
  } state_t;

  state_t state_reg, state_next;

  logic [15:0]       num_blocks_reg;
  logic              abort_pending_reg;
  logic [8:0]        byte_cnt_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [DATA_W-1:0] word_reg;
  logic [DATA_W-1:0] word_merged;
  logic              bav_prev_reg;

  logic [DATA_W-1:0] mem [FIFO_WORDS];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg;

  logic start_accept, capture, block_end, last_block;
  logic push_req, push, pop, full;
  logic [AW:0] free_words;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  assign start_accept = start && (state_reg == IDLE);
  // One capture per strobe: only the rising edge of the level strobe counts.
  assign capture      = (state_reg == RECV) && sd_byte_available && !bav_prev_reg;
  assign block_end    = capture && (byte_cnt_reg == 9'd511);
  assign last_block   = ((blocks_done + 16'd1) == num_blocks_reg);

  assign full       = (count_reg == DEPTH);
  assign free_words = DEPTH - count_reg;
  assign m_valid    = (count_reg != '0);
  assign push_req   = capture && (lane_reg == LAST_LANE);
  // A word arriving on a full FIFO is lost even if a pop happens this cycle.
  assign push       = push_req && !full;
  assign pop        = m_valid && m_ready;
  assign busy       = (state_reg != IDLE);

  // Incoming byte lands in the lane selected by lane_reg; the merged word is
  // what gets pushed when the last lane fills.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign word_merged[gi*8 +: 8] = (lane_reg == LANE_W'(gi)) ? sd_dout
                                                                 : word_reg[gi*8 +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sd_rd      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (num_blocks != 16'd0)) begin
          state_next = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (abort) begin
          state_next = IDLE;
        end else if ((free_words >= NEED) && sd_ready) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        sd_rd = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next = RECV;
        end
      end
      RECV: begin
        if (block_end) begin
          // Completion of the final block takes priority over a pending abort.
          if (last_block || abort_pending_reg || abort) begin
            state_next = IDLE;
          end else begin
            state_next = WAIT_SPACE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run control, byte packing and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      num_blocks_reg    <= '0;
      sd_address        <= '0;
      blocks_done       <= '0;
      overflow          <= 1'b0;
      done              <= 1'b0;
      abort_pending_reg <= 1'b0;
      byte_cnt_reg      <= '0;
      lane_reg          <= '0;
      word_reg          <= '0;
      bav_prev_reg      <= 1'b0;
    end else begin
      bav_prev_reg <= sd_byte_available;
      done         <= 1'b0;
      if (start_accept) begin
        num_blocks_reg    <= num_blocks;
        sd_address        <= start_addr;
        blocks_done       <= '0;
        overflow          <= 1'b0;
        abort_pending_reg <= 1'b0;
        byte_cnt_reg      <= '0;
        lane_reg          <= '0;
        // A zero-block run completes immediately without leaving IDLE.
        done              <= (num_blocks == 16'd0);
      end else begin
        if ((state_reg == RECV) && abort) begin
          abort_pending_reg <= 1'b1;
        end
        if (capture) begin
          byte_cnt_reg <= byte_cnt_reg + 9'd1;
          lane_reg     <= (lane_reg == LAST_LANE) ? '0 : lane_reg + LANE_W'(1);
          word_reg     <= word_merged;
        end
        if (block_end) begin
          byte_cnt_reg <= '0;
          blocks_done  <= blocks_done + 16'd1;
          sd_address   <= sd_address + ADDR_STEP;
          done         <= last_block;
        end
        if (push_req && full) begin
          overflow <= 1'b1;
        end
        if (busy && (state_next == IDLE)) begin
          abort_pending_reg <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (show-ahead). Pointers are AW bits and wrap naturally; the
  // occupancy carries one extra bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25mhz) begin
    if (rst || start_accept) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (push) begin
      mem[wr_ptr_reg] <= word_merged;
    end
  end

  assign m_data = mem[rd_ptr_reg];

endmodule

// File: doc/sd_stream_reader.md
SD_STREAM_READER -- requirements
Module: sd_stream_reader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W      8     output word width; legal values 8, 16, 32
  FIFO_WORDS  512   output FIFO depth in words; power of 2, >= 4096/DATA_W
  ADDR_MODE   0     0 = byte addressing (SDSC, +512 per block); 1 = block addressing (SDHC, +1 per block)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Reset is rst, synchronous, active-high; the clock is clk_25mhz.
  clk_25mhz          in   1       system clock; all logic on the rising edge
  rst                in   1       synchronous active-high reset
  start              in   1       one-cycle request to begin a multi-block read
  start_addr         in   32      first block address, sampled on accepted start
  num_blocks         in   16      number of 512-byte blocks, sampled on accepted start
  abort              in   1       stop at the next block boundary
  sd_ready           in   1       sd_controller ready
  sd_byte_available  in   1       sd_controller byte strobe (level)
  sd_dout            in   8       sd_controller byte
  sd_rd              out  1       one-cycle read request to sd_controller
  sd_address         out  32      block address to sd_controller
  m_data             out  DATA_W  FIFO head word (show-ahead)
  m_valid            out  1       FIFO not empty
  m_ready            in   1       consumer pop; pops when m_valid && m_ready
  busy               out  1       high from accepted start until return to IDLE
  done               out  1       one-cycle pulse when all blocks have been received
  blocks_done        out  16      blocks fully received in the current run
  overflow           out  1       sticky; a word was dropped because the FIFO was full

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_SPACE, ISSUE and RECV.
REQ-004 IDLE: start is accepted only in IDLE and is ignored while busy.
REQ-005 Accepted start: latch start_addr and num_blocks; clear blocks_done, overflow, the byte-lane counter and the byte counter; flush the FIFO.
REQ-006 Accepted start with num_blocks==0: stay in IDLE; pulse done on the next cycle; busy stays low.
REQ-007 Accepted start with num_blocks!=0: go to WAIT_SPACE; busy=1.
REQ-008 WAIT_SPACE: go to ISSUE when the FIFO has free words >= 4096/DATA_W AND sd_ready==1.
REQ-009 ISSUE: assert sd_rd for exactly one cycle with sd_address valid; then go to RECV.
REQ-010 sd_address SHALL stay stable from ISSUE until the end of RECV.
REQ-011 RECV: a byte is captured only on a rising edge of sd_byte_available (registered previous value; one capture per strobe regardless of strobe length).
REQ-012 Byte packing: first byte of each word goes to bits [7:0], next byte to [15:8], and so on (little-endian).
REQ-013 A word is pushed when the DATA_W/8-th byte is captured; 512 is a multiple of every legal byte count, so no partial words occur.
REQ-014 After the 512th byte of a block is captured: blocks_done increments and the byte counter clears.
REQ-015 sd_address advances by 512 when ADDR_MODE==0 and by 1 when ADDR_MODE==1, wrapping modulo 2^32.
REQ-016 After the 512th byte, if blocks_done+1==num_blocks: go to IDLE, pulse done for 1 cycle, busy=0 in the same cycle; otherwise go to WAIT_SPACE.
REQ-017 abort in WAIT_SPACE or ISSUE-pending: go to IDLE next cycle; busy=0; no done pulse.
REQ-018 abort in RECV: set abort_pending; finish the current block (REQ-014); then go to IDLE with no done pulse; abort_pending clears.
REQ-019 FIFO push when full: the word is dropped and overflow=1, even if a pop occurs in the same cycle.
REQ-020 Pop when empty SHALL be ignored.
REQ-021 Simultaneous push and pop when not full: both take effect and the occupancy is unchanged.
REQ-022 The FIFO keeps draining after IDLE is reached; its contents persist until the next accepted start or rst.
REQ-023 Pointers and occupancy SHALL be wide enough to distinguish full from empty at FIFO_WORDS.

Reset
REQ-024 While rst=1 and on the cycle after it: state=IDLE, sd_rd=0, sd_address=0, busy=0, done=0, blocks_done=0, overflow=0, m_valid=0, FIFO empty, byte counters=0, abort_pending=0.
REQ-025 rst asserted mid-RECV SHALL force the REQ-024 state immediately; no done pulse.

Verification
REQ-026 DATA_W=8, ADDR_MODE=0, start_addr=0x1000, num_blocks=2, m_ready=1 -> two sd_rd pulses at addresses 0x1000 and 0x1200; 1024 words out in order; one done pulse; blocks_done=2.
REQ-027 DATA_W=32, ADDR_MODE=1, start_addr=7, num_blocks=3, bytes 00,01,02,03,... -> first word 0x03020100; 128 words per block; addresses 7, 8, 9.
REQ-028 m_ready=0 with FIFO_WORDS=512, DATA_W=8, num_blocks=2 -> the second sd_rd is withheld until at least 512 words are free; overflow stays 0.
REQ-029 abort asserted at byte 100 of block 0 of 4 -> block 0 completes (512 words); no further sd_rd; no done pulse; blocks_done=1.
REQ-030 num_blocks=0 -> no sd_rd; done pulses 1 cycle after start; start during busy -> ignored.
REQ-031 sd_byte_available held high for 3 cycles per byte -> exactly one capture per strobe; rst at byte 300 -> all outputs at reset values the next cycle.
